// File: rtl/cpu_pkg.sv
// Shared encodings for the 8-bit core sequencer: FSM states, instruction field positions, defaults.
// Pure declarations; no latency, no flow control.
// Not applicable: holds no logic and applies no backpressure.
package cpu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WB     = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERR    = 3'd6
    } state_t;

    // Instruction layout: [7:6] opcode, [5:4] A/dest, [3:2] B, [1] halt-after, [0] no-writeback
    localparam int OP_LO    = 6;
    localparam int RA_LO    = 4;
    localparam int RB_LO    = 2;
    localparam int HALT_BIT = 1;
    localparam int NOWB_BIT = 0;

    localparam int ALU_TIMEOUT_DEF = 8;

endpackage

// File: rtl/exec_watchdog.sv
// ALU watchdog: saturating count of EXEC cycles spent waiting for alu_done.
// Counter registered; expired is combinational from the count and fires on the cycle that would reach TIMEOUT.
// No backpressure; TIMEOUT=0 disables expiry.
module exec_watchdog #(
    parameter int TIMEOUT = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(TIMEOUT);
    localparam logic [CNT_W:0]   LIMIT_X = (CNT_W + 1)'(TIMEOUT);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W:0]   cnt_inc;

    assign cnt_inc = {1'b0, cnt} + 1'b1;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (enable && (cnt != LIMIT)) begin
            cnt <= cnt + 1'b1;
        end
    end

    // The current waiting cycle is the TIMEOUT-th one: leave EXEC at its end.
    assign expired = (TIMEOUT != 0) && enable && (cnt_inc >= LIMIT_X);

endmodule

// File: rtl/exec_sequencer.sv
// Fetch/decode/execute/writeback controller for the 8-bit core, with ALU watchdog.
// Min 4 cycles per instruction (FETCH, DECODE, EXEC, WB); all outputs come straight from flops.
// Waits in EXEC for alu_done (bounded by watchdog); str is honoured only in IDLE/DONE/ERR.
module exec_sequencer
    import cpu_pkg::*;
#(
    parameter int ADDR_W      = 2,
    parameter int DATA_W      = 8,
    parameter int PROG_LEN    = 4,
    parameter int ALU_TIMEOUT = ALU_TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              str,
    output logic [ADDR_W-1:0] instr_addr,
    input  logic [DATA_W-1:0] instr_data,
    output logic [ADDR_W-1:0] rf_addr_a,
    output logic [ADDR_W-1:0] rf_addr_b,
    output logic [1:0]        alu_opcode,
    output logic              alu_start,
    input  logic              alu_done,
    input  logic [DATA_W-1:0] alu_result,
    output logic              rf_wr_en,
    output logic [ADDR_W-1:0] rf_wr_addr,
    output logic [DATA_W-1:0] rf_wr_data,
    output logic              busy,
    output logic              halted,
    output logic              error,
    output logic [2:0]        state,
    output logic [DATA_W-1:0] retired
);

    localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(PROG_LEN - 1);

    state_t            st, st_nxt;
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] ir;
    logic [DATA_W-1:0] res;
    logic              wd_expired;
    logic              restart;

    // Field outputs are plain slices of the IR flop, so they stay registered and stable all instruction.
    assign state      = st;
    assign instr_addr = pc;
    assign rf_addr_a  = ir[RA_LO +: ADDR_W];
    assign rf_addr_b  = ir[RB_LO +: ADDR_W];
    assign rf_wr_addr = ir[RA_LO +: ADDR_W];
    assign alu_opcode = ir[OP_LO +: 2];
    assign rf_wr_data = res;

    assign restart = str && ((st == ST_IDLE) || (st == ST_DONE) || (st == ST_ERR));

    exec_watchdog #(
        .TIMEOUT (ALU_TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (st == ST_DECODE),
        .enable  (st == ST_EXEC),
        .expired (wd_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            st <= ST_IDLE;
        end else begin
            st <= st_nxt;
        end
    end

    always_comb begin
        st_nxt = st;
        case (st)
            ST_IDLE, ST_DONE, ST_ERR: if (str) st_nxt = ST_FETCH;
            ST_FETCH:  st_nxt = ST_DECODE;
            ST_DECODE: st_nxt = ST_EXEC;
            ST_EXEC: begin
                if (alu_done) begin
                    st_nxt = ST_WB;
                end else if (wd_expired) begin
                    st_nxt = ST_ERR;
                end
            end
            ST_WB: st_nxt = (ir[HALT_BIT] || (pc == LAST_PC)) ? ST_DONE : ST_FETCH;
            default: st_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc        <= '0;
            ir        <= '0;
            res       <= '0;
            alu_start <= 1'b0;
            rf_wr_en  <= 1'b0;
            busy      <= 1'b0;
            halted    <= 1'b0;
            error     <= 1'b0;
            retired   <= '0;
        end else begin
            alu_start <= (st == ST_DECODE);
            rf_wr_en  <= 1'b0;
            busy      <= (st_nxt == ST_FETCH) || (st_nxt == ST_DECODE) ||
                         (st_nxt == ST_EXEC)  || (st_nxt == ST_WB);
            halted    <= (st_nxt == ST_DONE);
            error     <= (st_nxt == ST_ERR);
            if (restart) begin
                pc <= '0;
            end
            if (st == ST_FETCH) begin
                ir <= instr_data;
            end
            // Strobe is armed on the EXEC->WB edge so it is visible during the WB cycle.
            if ((st == ST_EXEC) && alu_done) begin
                res      <= alu_result;
                rf_wr_en <= ~ir[NOWB_BIT];
            end
            if (st == ST_WB) begin
                retired <= retired + 1'b1;
                pc      <= pc + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed bench for exec_sequencer: instruction ROM and ALU stub with programmable latency.
module tb_exec_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       str;
    logic [1:0] instr_addr;
    logic [7:0] instr_data;
    logic [1:0] rf_addr_a, rf_addr_b, alu_opcode, rf_wr_addr;
    logic       alu_start, alu_done, rf_wr_en, busy, halted, error;
    logic [7:0] alu_result, rf_wr_data, retired;
    logic [2:0] state;

    logic [7:0] prog [4];
    logic [7:0] res_base;
    int         stub_lat;
    logic       stub_act = 1'b0;
    int         stub_cnt = 0;

    typedef struct {
        logic [1:0] pc;
        logic [1:0] addr;
        logic [7:0] data;
    } wr_t;
    wr_t wq[$];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    exec_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .str        (str),
        .instr_addr (instr_addr),
        .instr_data (instr_data),
        .rf_addr_a  (rf_addr_a),
        .rf_addr_b  (rf_addr_b),
        .alu_opcode (alu_opcode),
        .alu_start  (alu_start),
        .alu_done   (alu_done),
        .alu_result (alu_result),
        .rf_wr_en   (rf_wr_en),
        .rf_wr_addr (rf_wr_addr),
        .rf_wr_data (rf_wr_data),
        .busy       (busy),
        .halted     (halted),
        .error      (error),
        .state      (state),
        .retired    (retired)
    );

    assign instr_data = prog[instr_addr];
    assign alu_result = res_base + {6'b0, instr_addr};
    assign alu_done   = (stub_lat == 0 && alu_start === 1'b1) ||
                        (stub_lat > 0 && stub_act && stub_cnt == stub_lat);

    always @(posedge clk) begin
        if (reset) begin
            stub_act <= 1'b0;
        end else if (alu_start && !alu_done) begin
            stub_act <= 1'b1;
            stub_cnt <= 1;
        end else if (stub_act && alu_done) begin
            stub_act <= 1'b0;
        end else if (stub_act) begin
            stub_cnt <= stub_cnt + 1;
        end
    end

    always @(negedge clk) begin
        if (rf_wr_en === 1'b1) wq.push_back('{instr_addr, rf_wr_addr, rf_wr_data});
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        str   = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        wq.delete();
    endtask

    task automatic wait_halt(input int max_cyc, output int cyc);
        cyc = 0;
        while (halted !== 1'b1 && cyc < max_cyc) begin
            tick();
            cyc++;
        end
    endtask

    function automatic logic [63:0] all_outs();
        return {30'b0, instr_addr, rf_addr_a, rf_addr_b, alu_opcode, alu_start, rf_wr_en,
                rf_wr_addr, rf_wr_data, busy, halted, error, state, retired};
    endfunction

    initial begin
        int cyc;
        prog     = '{8'h00, 8'h00, 8'h00, 8'h00};
        res_base = 8'h00;
        stub_lat = 0;

        // Reset state; all outputs stay zero while idle with str low
        reset = 1'b1;
        str   = 1'b0;
        tick();
        check("in_reset_outs", all_outs(), 64'h0);
        repeat (2) tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("idle_outs", all_outs(), 64'h0);
        end

        // Single ADD, ALU done in the start cycle
        do_reset();
        prog[0]  = 8'b00_01_00_00;
        prog[1]  = 8'b00_10_00_10;
        res_base = 8'h03;
        stub_lat = 0;
        str = 1'b1;
        tick();
        str = 1'b0;
        check("t2_fetch_state", state, 3'd1);
        check("t2_fetch_busy", busy, 1'b1);
        tick();
        check("t2_decode_state", state, 3'd2);
        check("t2_decode_ra", rf_addr_a, 2'd1);
        tick();
        check("t2_exec_start", {state, alu_start}, {3'd3, 1'b1});
        tick();
        check("t2_wb_state", state, 3'd4);
        check("t2_wb_strobe", {rf_wr_en, rf_wr_addr, rf_wr_data}, {1'b1, 2'd1, 8'h03});
        tick();
        check("t2_after_wb", {state, rf_wr_en, instr_addr, retired}, {3'd1, 1'b0, 2'd1, 8'd1});

        // Full program, ALU latency 2
        do_reset();
        prog     = '{8'h44, 8'h98, 8'hEC, 8'h30};
        res_base = 8'h20;
        stub_lat = 2;
        str = 1'b1;
        tick();
        str = 1'b0;
        wait_halt(60, cyc);
        check("t3_cycles_to_done", cyc, 24);
        check("t3_num_writes", wq.size(), 4);
        for (int i = 0; i < 4 && i < wq.size(); i++) begin
            check("t3_write", {wq[i].pc, wq[i].addr, wq[i].data}, {2'(i), 2'(i), 8'h20 + 8'(i)});
        end
        check("t3_done", {state, halted, busy, retired}, {3'd5, 1'b1, 1'b0, 8'd4});
        check("t3_pc_wrap", instr_addr, 2'd0);

        // Halt-after on instruction 1, which also suppresses writeback
        do_reset();
        prog     = '{8'h44, 8'h9B, 8'h30, 8'h30};
        res_base = 8'h30;
        stub_lat = 0;
        str = 1'b1;
        tick();
        str = 1'b0;
        wait_halt(30, cyc);
        check("t4_cycles_to_done", cyc, 8);
        check("t4_done", {state, halted, retired, instr_addr}, {3'd5, 1'b1, 8'd2, 2'd2});
        check("t4_num_writes", wq.size(), 1);
        if (wq.size() > 0) check("t4_write0", {wq[0].pc, wq[0].addr, wq[0].data}, {2'd0, 2'd0, 8'h30});
        str = 1'b1;
        tick();
        str = 1'b0;
        check("t4_restart", {state, instr_addr, retired, halted}, {3'd1, 2'd0, 8'd2, 1'b0});

        // Watchdog: ALU stops answering on instruction 1
        do_reset();
        prog     = '{8'h44, 8'h98, 8'h30, 8'h30};
        res_base = 8'h50;
        stub_lat = 0;
        str = 1'b1;
        tick();
        str = 1'b0;
        repeat (3) tick();
        check("t5_first_wb", {state, rf_wr_en}, {3'd4, 1'b1});
        stub_lat = -1;
        repeat (3) tick();
        check("t5_exec_entry", {state, alu_start, instr_addr}, {3'd3, 1'b1, 2'd1});
        repeat (7) tick();
        check("t5_last_wait", {state, error}, {3'd3, 1'b0});
        tick();
        check("t5_err", {state, error, busy, instr_addr, retired}, {3'd6, 1'b1, 1'b0, 2'd1, 8'd1});
        tick();
        check("t5_err_hold", {state, error, instr_addr}, {3'd6, 1'b1, 2'd1});
        str = 1'b1;
        tick();
        str = 1'b0;
        check("t5_restart", {state, instr_addr, error, busy}, {3'd1, 2'd0, 1'b0, 1'b1});

        // Reset during EXEC, with str pulsed while busy
        do_reset();
        prog     = '{8'h10, 8'h98, 8'h30, 8'h30};
        res_base = 8'h60;
        stub_lat = 3;
        str = 1'b1;
        tick();
        str = 1'b0;
        tick();
        str = 1'b1;
        tick();
        check("t6_busy_str_ignored", {state, instr_addr}, {3'd3, 2'd0});
        tick();
        str = 1'b0;
        check("t6_still_exec", state, 3'd3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t6_reset_outs", all_outs(), 64'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t6_idle_after_reset", all_outs(), 64'h0);
        end
        check("t6_no_writes", wq.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
